// File: rtl/seq_divider_hs_if.sv
// Request/response handshake bundle for seq_divider_hs.
// The i_flush abort line exists only when SEQ_DIV_ABORT_EN is defined.
interface seq_divider_hs_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_dividend;
    logic [WIDTH-1:0]     i_divisor;
    logic                 i_is_unsigned;
    logic [TAG_WIDTH-1:0] i_tag;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH-1:0]     o_quotient;
    logic [WIDTH-1:0]     o_remainder;
    logic                 o_div_by_zero;
    logic [TAG_WIDTH-1:0] o_tag;
    logic                 o_busy;
`ifdef SEQ_DIV_ABORT_EN
    logic                 i_flush;
`endif

    modport slave (
`ifdef SEQ_DIV_ABORT_EN
        input  i_flush,
`endif
        input  i_valid, i_dividend, i_divisor, i_is_unsigned, i_tag, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero, o_tag, o_busy
    );

    modport master (
`ifdef SEQ_DIV_ABORT_EN
        output i_flush,
`endif
        output i_valid, i_dividend, i_divisor, i_is_unsigned, i_tag, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero, o_tag, o_busy
    );
endinterface

// File: rtl/seq_divider_hs.sv
// Multi-cycle non-restoring integer divider (DIV/DIVU/REM/REMU), one operation in flight.
// Optional abort input enabled by defining SEQ_DIV_ABORT_EN.
module seq_divider_hs #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
) (
    input logic             clk,
    input logic             resetn,
    seq_divider_hs_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       rem;       // partial remainder, MSB is its sign
    logic [WIDTH-1:0]     quo;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     dvd_raw;
    logic                 quo_neg, rem_neg, dvs_zero, ovf;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     quo_out, rem_out;
    logic                 dbz_out;
    logic [TAG_WIDTH-1:0] tag_out;

    logic flush;
`ifdef SEQ_DIV_ABORT_EN
    assign flush = bus.i_flush;
`else
    assign flush = 1'b0;
`endif

    logic accept, last_step;
    assign accept    = bus.i_valid && (state == IDLE) && !flush;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)      state_next = CALC;
            CALC: if (last_step)   state_next = FIX;
            FIX:                   state_next = DONE;
            DONE: if (bus.i_ready) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Operand preparation for the accepting edge.
    logic             dvd_sign, dvs_sign;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    always_comb begin
        dvd_sign = !bus.i_is_unsigned && bus.i_dividend[WIDTH-1];
        dvs_sign = !bus.i_is_unsigned && bus.i_divisor[WIDTH-1];
        dvd_mag  = dvd_sign ? -bus.i_dividend : bus.i_dividend;
        dvs_mag  = dvs_sign ? -bus.i_divisor  : bus.i_divisor;
    end

    // One non-restoring step: add or subtract the divisor depending on the current remainder sign.
    logic [WIDTH:0]   rem_shift, rem_step;
    logic [WIDTH-1:0] quo_step;
    always_comb begin
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_step  = rem[WIDTH] ? rem_shift + {1'b0, dvs} : rem_shift - {1'b0, dvs};
        quo_step  = {quo[WIDTH-2:0], !rem_step[WIDTH]};
    end

    // Final correction, sign application and special-case override.
    logic [WIDTH:0]   rem_fix;
    logic [WIDTH-1:0] quo_res, rem_res;
    always_comb begin
        rem_fix = rem[WIDTH] ? rem + {1'b0, dvs} : rem;
        quo_res = quo_neg ? -quo : quo;
        rem_res = rem_neg ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
        if (dvs_zero) begin
            quo_res = '1;
            rem_res = dvd_raw;
        end else if (ovf) begin
            quo_res = dvd_raw;
            rem_res = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dvs_zero <= 1'b0;
            ovf      <= 1'b0;
            tag      <= '0;
            quo_out  <= '0;
            rem_out  <= '0;
            dbz_out  <= 1'b0;
            tag_out  <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                rem      <= '0;
                quo      <= dvd_mag;
                dvs      <= dvs_mag;
                dvd_raw  <= bus.i_dividend;
                dvs_zero <= (bus.i_divisor == '0);
                quo_neg  <= (dvd_sign ^ dvs_sign) && (bus.i_divisor != '0);
                rem_neg  <= dvd_sign;
                ovf      <= !bus.i_is_unsigned && (bus.i_divisor == '1) &&
                            (bus.i_dividend == {1'b1, {(WIDTH-1){1'b0}}});
                tag      <= bus.i_tag;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                rem <= rem_step;
                quo <= quo_step;
            end
            if (state == FIX && !flush) begin
                quo_out <= quo_res;
                rem_out <= rem_res;
                dbz_out <= dvs_zero;
                tag_out <= tag;
            end
        end
    end

    assign bus.o_ready       = (state == IDLE);
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_valid       = (state == DONE);
    assign bus.o_quotient    = quo_out;
    assign bus.o_remainder   = rem_out;
    assign bus.o_div_by_zero = dbz_out;
    assign bus.o_tag         = tag_out;
endmodule
